syn_lifo_ext: RTL and testbench
===============================

SYN_LIFO_EXT -- requirements
Module: syn_lifo_ext

Interface
REQ-001 SHALL have parameter data_width, default 8, meaning word width in bits (>=1).
REQ-002 SHALL have parameter depth, default 8, meaning number of entries (>=2, any integer, not restricted to powers of two).
REQ-003 SHALL have parameter af_level, default depth-1, meaning almost_full asserts when count >= af_level.
REQ-004 SHALL have parameter ae_level, default 1, meaning almost_empty asserts when count <= ae_level.
REQ-005 SHALL have port clk, input, 1 bit: single clock, all state on the rising edge.
REQ-006 SHALL have port clr, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port push, input, 1 bit: write request.
REQ-008 SHALL have port pop, input, 1 bit: read request.
REQ-009 SHALL have port data_in, input, data_width bits: word to push.
REQ-010 SHALL have port err_clr, input, 1 bit: synchronous clear of the sticky error flags.
REQ-011 SHALL have port data_out, output, data_width bits: registered popped word.
REQ-012 SHALL have port data_valid, output, 1 bit: one-cycle pulse qualifying data_out.
REQ-013 SHALL have port top, output, data_width bits: combinational peek of the top entry, 0 when empty.
REQ-014 SHALL have port count, output, $clog2(depth+1) bits: current occupancy.
REQ-015 SHALL have ports full, empty, almost_full and almost_empty, each output, 1 bit, decoded combinationally from count.
REQ-016 SHALL have ports overflow and underflow, each output, 1 bit: sticky error flags.

Function
REQ-017 Push only, not full: SHALL write mem[count] <= data_in and increment count.
REQ-018 Push only, full: SHALL leave memory and count unchanged and set overflow.
REQ-019 Pop only, not empty: SHALL load data_out <= mem[count-1], decrement count and pulse data_valid the next cycle (1-cycle latency).
REQ-020 Pop only, empty: SHALL set underflow, hold data_out and keep data_valid at 0.
REQ-021 Push and pop together, not empty: SHALL replace the top entry; data_out <= old mem[count-1], mem[count-1] <= data_in, count unchanged, data_valid pulses; this SHALL also apply when full, with no overflow.
REQ-022 Push and pop together, empty: SHALL bypass; data_out <= data_in, data_valid pulses, count stays 0, no underflow.
REQ-023 data_valid SHALL be 0 in every cycle not immediately following an accepted pop.
REQ-024 Outside the ranges 0..depth, count SHALL never wrap; full = (count == depth) and empty = (count == 0).
REQ-025 err_clr SHALL clear overflow and underflow; if a new error occurs in the same cycle, the set SHALL take priority.
REQ-026 Memory contents SHALL NOT be reset; top SHALL return 0 when empty regardless of stale memory.

Reset
REQ-027 While clr is high, count, data_out, data_valid, overflow and underflow SHALL be 0 immediately, independent of clk.
REQ-028 A reset asserted mid-operation SHALL discard all stored entries, so that empty = 1 and almost_empty = 1 on assertion.
REQ-029 The first operation SHALL be accepted on the first rising clk edge after clr deasserts.

Structure
REQ-030 The shared package syn_lifo_pkg SHALL hold the default data_width and depth and an op-encoding constant set: OP_IDLE, OP_PUSH, OP_POP, OP_REPL.
REQ-031 Storage SHALL be a sub-module lifo_ram with one synchronous write port and one asynchronous read port, no reset.
REQ-032 The pointer, flags and data_out logic SHALL reside in syn_lifo_ext, decoding {push,pop} into an op.

Verification (depth=4, data_width=8)
REQ-033 Reset then push 0x11,0x22,0x33,0x44 -> full=1, count=4, top=0x44; a fifth push of 0x55 -> overflow=1, top=0x44.
REQ-034 From full, pop four times -> data_out 0x44,0x33,0x22,0x11, each with a data_valid pulse one cycle after its pop, then empty=1.
REQ-035 Pop when empty -> underflow=1 and data_valid=0; err_clr -> underflow=0.
REQ-036 Stack of 0x11,0x22, push+pop with 0xAA -> data_out=0x22, count=2, top=0xAA; when empty, push+pop with 0x5C -> data_out=0x5C, count=0.
REQ-037 Assert clr asynchronously between edges with count=3 -> count=0, empty=1 and data_valid=0 before the next edge.
REQ-038 af_level=3, ae_level=1: sweep count 0..4 -> almost_empty at 0-1 and almost_full at 3-4.

Source files
------------

// File: rtl/syn_lifo_pkg.sv
// Shared defaults and push/pop operation encoding
// for the synchronous LIFO.
package syn_lifo_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 8;

  // Encoding matches the {push, pop} request pair.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_REPL = 2'b11
  } op_e;

  function automatic op_e decode_op(
    input logic push,
    input logic pop
  );
    return op_e'({push, pop});
  endfunction

endpackage

// File: rtl/lifo_ram.sv
// LIFO storage: one synchronous write port,
// one asynchronous read port, contents never reset.
module lifo_ram #(
  parameter int W  = 8,
  parameter int D  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [D];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/syn_lifo_ext.sv
// Synchronous LIFO with registered pop data, replace/bypass,
// threshold flags and sticky overflow/underflow.
module syn_lifo_ext
  import syn_lifo_pkg::*;
#(
  parameter int data_width = DATA_WIDTH,
  parameter int depth      = DEPTH,
  parameter int af_level   = depth - 1,
  parameter int ae_level   = 1,
  localparam int CW        = $clog2(depth + 1)
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  pop,
  input  logic [data_width-1:0] data_in,
  input  logic                  err_clr,
  output logic [data_width-1:0] data_out,
  output logic                  data_valid,
  output logic [data_width-1:0] top,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int AW = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(depth);
  localparam logic [CW-1:0] AF_CNT   = CW'(af_level);
  localparam logic [CW-1:0] AE_CNT   = CW'(ae_level);

  logic [CW-1:0]         count_q, count_d;
  logic [data_width-1:0] dout_q, dout_d;
  logic                  dv_q, dv_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic                  we;
  logic [AW-1:0]         waddr;
  logic [AW-1:0]         raddr;
  logic [data_width-1:0] rdata;
  logic [CW-1:0]         cnt_m1;
  logic                  ovf_set;
  logic                  unf_set;
  op_e                   op;

  assign op     = decode_op(push, pop);
  assign cnt_m1 = count_q - CW'(1);

  assign full         = (count_q == FULL_CNT);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_CNT);
  assign almost_empty = (count_q <= AE_CNT);

  // Clamp so an empty stack never reads past the array.
  assign raddr = empty ? '0 : cnt_m1[AW-1:0];
  assign top   = empty ? '0 : rdata;

  lifo_ram #(
    .W  (data_width),
    .D  (depth),
    .AW (AW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (data_in),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_comb begin
    count_d = count_q;
    dout_d  = dout_q;
    dv_d    = 1'b0;
    we      = 1'b0;
    waddr   = raddr;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    unique case (op)
      OP_PUSH: begin
        if (full) begin
          ovf_set = 1'b1;
        end else begin
          we      = 1'b1;
          waddr   = count_q[AW-1:0];
          count_d = count_q + CW'(1);
        end
      end
      OP_POP: begin
        if (empty) begin
          unf_set = 1'b1;
        end else begin
          dout_d  = rdata;
          dv_d    = 1'b1;
          count_d = cnt_m1;
        end
      end
      OP_REPL: begin
        // Empty replace is a straight bypass of data_in.
        dv_d = 1'b1;
        if (empty) begin
          dout_d = data_in;
        end else begin
          dout_d = rdata;
          we     = 1'b1;
        end
      end
      default: begin
      end
    endcase
    ovf_d = ovf_set | (ovf_q & ~err_clr);
    unf_d = unf_set | (unf_q & ~err_clr);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count_q <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count      = count_q;
  assign data_out   = dout_q;
  assign data_valid = dv_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

endmodule

// File: tb/tb_syn_lifo_ext.sv
// Directed vector bench for syn_lifo_ext
// at depth 4, width 8, af_level 3, ae_level 1.
module tb_syn_lifo_ext;

  logic       clk;
  logic       clr;
  logic       push;
  logic       pop;
  logic [7:0] data_in;
  logic       err_clr;
  logic [7:0] data_out;
  logic       data_valid;
  logic [7:0] top;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       push;
    logic       pop;
    logic       ec;
    logic [7:0] din;
    logic [2:0] cnt;
    logic [7:0] top;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       dv;
    logic [7:0] dout;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t vq[$];

  syn_lifo_ext #(
    .data_width (8),
    .depth      (4),
    .af_level   (3),
    .ae_level   (1)
  ) dut (
    .clk          (clk),
    .clr          (clr),
    .push         (push),
    .pop          (pop),
    .data_in      (data_in),
    .err_clr      (err_clr),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .top          (top),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h",
               nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input vec_t v);
    chk("count", idx, 32'(count), 32'(v.cnt));
    chk("top", idx, 32'(top), 32'(v.top));
    chk("full", idx, 32'(full), 32'(v.full));
    chk("empty", idx, 32'(empty), 32'(v.empty));
    chk("almost_full", idx, 32'(almost_full), 32'(v.af));
    chk("almost_empty", idx, 32'(almost_empty), 32'(v.ae));
    chk("data_valid", idx, 32'(data_valid), 32'(v.dv));
    chk("data_out", idx, 32'(data_out), 32'(v.dout));
    chk("overflow", idx, 32'(overflow), 32'(v.ovf));
    chk("underflow", idx, 32'(underflow), 32'(v.unf));
  endtask

  initial begin
    // push pop ec din | cnt top full empty af ae dv dout ovf unf
    vq.push_back('{0,0,0,8'h00, 0,8'h00,0,1,0,1,0,8'h00,0,0});
    vq.push_back('{1,0,0,8'h11, 1,8'h11,0,0,0,1,0,8'h00,0,0});
    vq.push_back('{1,0,0,8'h22, 2,8'h22,0,0,0,0,0,8'h00,0,0});
    vq.push_back('{1,0,0,8'h33, 3,8'h33,0,0,1,0,0,8'h00,0,0});
    vq.push_back('{1,0,0,8'h44, 4,8'h44,1,0,1,0,0,8'h00,0,0});
    vq.push_back('{1,0,0,8'h55, 4,8'h44,1,0,1,0,0,8'h00,1,0});
    vq.push_back('{0,1,0,8'h00, 3,8'h33,0,0,1,0,1,8'h44,1,0});
    vq.push_back('{0,1,0,8'h00, 2,8'h22,0,0,0,0,1,8'h33,1,0});
    vq.push_back('{0,1,1,8'h00, 1,8'h11,0,0,0,1,1,8'h22,0,0});
    vq.push_back('{0,1,0,8'h00, 0,8'h00,0,1,0,1,1,8'h11,0,0});
    vq.push_back('{0,0,0,8'h00, 0,8'h00,0,1,0,1,0,8'h11,0,0});
    vq.push_back('{0,1,0,8'h00, 0,8'h00,0,1,0,1,0,8'h11,0,1});
    vq.push_back('{0,0,1,8'h00, 0,8'h00,0,1,0,1,0,8'h11,0,0});
    vq.push_back('{0,1,1,8'h00, 0,8'h00,0,1,0,1,0,8'h11,0,1});
    vq.push_back('{0,0,1,8'h00, 0,8'h00,0,1,0,1,0,8'h11,0,0});
    vq.push_back('{1,1,0,8'h5C, 0,8'h00,0,1,0,1,1,8'h5C,0,0});
    vq.push_back('{1,0,0,8'h11, 1,8'h11,0,0,0,1,0,8'h5C,0,0});
    vq.push_back('{1,0,0,8'h22, 2,8'h22,0,0,0,0,0,8'h5C,0,0});
    vq.push_back('{1,1,0,8'hAA, 2,8'hAA,0,0,0,0,1,8'h22,0,0});
    vq.push_back('{0,1,0,8'h00, 1,8'h11,0,0,0,1,1,8'hAA,0,0});
    vq.push_back('{1,0,0,8'h33, 2,8'h33,0,0,0,0,0,8'hAA,0,0});
    vq.push_back('{1,0,0,8'h44, 3,8'h44,0,0,1,0,0,8'hAA,0,0});
    vq.push_back('{1,0,0,8'h55, 4,8'h55,1,0,1,0,0,8'hAA,0,0});
    vq.push_back('{1,1,0,8'h66, 4,8'h66,1,0,1,0,1,8'h55,0,0});
    vq.push_back('{0,1,0,8'h00, 3,8'h44,0,0,1,0,1,8'h66,0,0});

    clr     = 1'b1;
    push    = 1'b0;
    pop     = 1'b0;
    data_in = '0;
    err_clr = 1'b0;

    @(negedge clk);
    chk_all(-1, '{0,0,0,8'h00, 0,8'h00,0,1,0,1,0,8'h00,0,0});
    clr = 1'b0;

    foreach (vq[i]) begin
      push    = vq[i].push;
      pop     = vq[i].pop;
      err_clr = vq[i].ec;
      data_in = vq[i].din;
      @(posedge clk);
      @(negedge clk);
      chk_all(i, vq[i]);
    end

    // Mid-cycle asynchronous reset with count=3 and data_valid high.
    push    = 1'b0;
    pop     = 1'b0;
    err_clr = 1'b0;
    data_in = '0;
    #2 clr = 1'b1;
    #1;
    chk("clr_count", 100, 32'(count), 32'd0);
    chk("clr_empty", 100, 32'(empty), 32'd1);
    chk("clr_almost_empty", 100, 32'(almost_empty), 32'd1);
    chk("clr_data_valid", 100, 32'(data_valid), 32'd0);
    chk("clr_data_out", 100, 32'(data_out), 32'd0);
    chk("clr_top", 100, 32'(top), 32'd0);

    // First edge after release must accept the push.
    @(negedge clk);
    clr     = 1'b0;
    push    = 1'b1;
    data_in = 8'h77;
    @(posedge clk);
    @(negedge clk);
    chk("post_clr_count", 101, 32'(count), 32'd1);
    chk("post_clr_top", 101, 32'(top), 32'h77);
    chk("post_clr_dv", 101, 32'(data_valid), 32'd0);

    push = 1'b0;
    pop  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pop = 1'b0;
    chk("post_clr_pop", 102, 32'(data_out), 32'h77);
    chk("post_clr_pop_dv", 102, 32'(data_valid), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("dv_drop", 103, 32'(data_valid), 32'd0);
    chk("dout_hold", 103, 32'(data_out), 32'h77);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
